// File: rtl/ftq_fetch_target_queue_pkg.sv
// Shared types and constants for the fetch target queue.
package ftq_fetch_target_queue_pkg;

    localparam int unsigned FTQ_DEPTH = 8;
    localparam int unsigned FTQ_PTR_W = 3;

    localparam logic [1:0] BRANCH_TYPE_NONE = 2'd0;
    localparam logic [1:0] BRANCH_TYPE_COND = 2'd1;
    localparam logic [1:0] BRANCH_TYPE_JUMP = 2'd2;
    localparam logic [1:0] BRANCH_TYPE_RET  = 2'd3;

    // One uBTB prediction per fetch block.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] target;
        logic [1:0]  cut_pos;
        logic        hit;
        logic [1:0]  branch_type;
    } ftq_entry_t;

    // Sequential next fetch PC when no branch is taken.
    function automatic logic [31:0] ftq_fallthrough(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/ftq_fetch_target_queue_ptr_ctrl.sv
// Head/fptr/tail pointer control: occupancy, resolve legality and flush rewind.
module ftq_fetch_target_queue_ptr_ctrl
    import ftq_fetch_target_queue_pkg::*;
#(
    parameter int unsigned PTR_W = FTQ_PTR_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enq_i,
    input  logic             deq_i,
    input  logic             commit_i,
    input  logic             flush_i,
    input  logic [PTR_W-1:0] flush_idx_i,
    input  logic [PTR_W-1:0] res_idx_i,
    output logic [PTR_W-1:0] tail_idx_o,
    output logic [PTR_W-1:0] fptr_idx_o,
    output logic             full_o,
    output logic             deq_avail_o,
    output logic             res_legal_o,
    output logic [PTR_W:0]   count_o
);

    typedef logic [PTR_W:0] ptr_t;

    ptr_t             head_q, head_d;
    ptr_t             fptr_q, fptr_d;
    ptr_t             tail_q, tail_d;
    ptr_t             issued_dist;
    logic [PTR_W-1:0] res_rel;
    logic [PTR_W-1:0] flush_rel;

    // Next-state pointers; a flush rewinds fptr/tail relative to head so the wrap bit stays right.
    always_comb begin
        issued_dist = fptr_q - head_q;
        res_rel     = res_idx_i - head_q[PTR_W-1:0];
        res_legal_o = {1'b0, res_rel} < issued_dist;
        flush_rel   = flush_idx_i - head_q[PTR_W-1:0];

        head_d = head_q;
        if (commit_i && (head_q != fptr_q)) begin
            head_d = head_q + ptr_t'(1);
        end

        fptr_d = fptr_q + {{PTR_W{1'b0}}, deq_i};
        tail_d = tail_q + {{PTR_W{1'b0}}, enq_i};
        if (flush_i) begin
            fptr_d = head_q + {1'b0, flush_rel} + ptr_t'(1);
            tail_d = head_q + {1'b0, flush_rel} + ptr_t'(1);
        end
    end

    // Pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q <= '0;
            fptr_q <= '0;
            tail_q <= '0;
        end else begin
            head_q <= head_d;
            fptr_q <= fptr_d;
            tail_q <= tail_d;
        end
    end

    assign tail_idx_o  = tail_q[PTR_W-1:0];
    assign fptr_idx_o  = fptr_q[PTR_W-1:0];
    assign full_o      = (head_q[PTR_W-1:0] == tail_q[PTR_W-1:0]) &&
                         (head_q[PTR_W] != tail_q[PTR_W]);
    assign deq_avail_o = (fptr_q != tail_q);
    assign count_o     = tail_q - head_q;

endmodule

// File: rtl/ftq_fetch_target_queue.sv
// Fetch target queue: buffers uBTB predictions, issues to IFU, checks resolves, redirects.
module ftq_fetch_target_queue
    import ftq_fetch_target_queue_pkg::*;
#(
    parameter int unsigned DEPTH = FTQ_DEPTH,
    parameter int unsigned PTR_W = FTQ_PTR_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enq_valid_i,
    output logic             enq_ready_o,
    input  logic [31:0]      enq_pc_i,
    input  logic [31:0]      enq_target_i,
    input  logic [1:0]       enq_cut_pos_i,
    input  logic             enq_hit_i,
    input  logic [1:0]       enq_branch_type_i,
    output logic             deq_valid_o,
    input  logic             deq_ready_i,
    output logic [31:0]      deq_pc_o,
    output logic [1:0]       deq_cut_pos_o,
    output logic [PTR_W-1:0] deq_idx_o,
    input  logic             res_valid_i,
    input  logic [PTR_W-1:0] res_idx_i,
    input  logic             res_taken_i,
    input  logic [31:0]      res_target_i,
    input  logic [1:0]       res_cut_pos_i,
    input  logic [1:0]       res_branch_type_i,
    input  logic             commit_valid_i,
    output logic             redirect_valid_o,
    output logic [31:0]      redirect_pc_o,
    output logic             ubtb_update_valid_o,
    output logic [31:0]      ubtb_update_pc_o,
    output logic [31:0]      ubtb_target_pc_o,
    output logic [1:0]       ubtb_update_cut_pos_o,
    output logic [1:0]       ubtb_update_branch_type_o,
    output logic [PTR_W:0]   count_o
);

    ftq_entry_t       entries_q [DEPTH];
    ftq_entry_t       res_entry;
    ftq_entry_t       deq_entry;
    logic [PTR_W-1:0] tail_idx, fptr_idx;
    logic             full, deq_avail, res_legal;
    logic             enq_fire, deq_fire;
    logic             res_ok, mispredict, upd_fire;
    logic [31:0]      actual_next;

    logic             redirect_valid_q;
    logic [31:0]      redirect_pc_q;
    logic             upd_valid_q;
    logic [31:0]      upd_pc_q, upd_target_q;
    logic [1:0]       upd_cut_q, upd_bt_q;

    ftq_fetch_target_queue_ptr_ctrl #(
        .PTR_W (PTR_W)
    ) u_ptr_ctrl (
        .clk         (clk),
        .rst_n       (rst_n),
        .enq_i       (enq_fire),
        .deq_i       (deq_fire),
        .commit_i    (commit_valid_i),
        .flush_i     (mispredict),
        .flush_idx_i (res_idx_i),
        .res_idx_i   (res_idx_i),
        .tail_idx_o  (tail_idx),
        .fptr_idx_o  (fptr_idx),
        .full_o      (full),
        .deq_avail_o (deq_avail),
        .res_legal_o (res_legal),
        .count_o     (count_o)
    );

    // Resolve compare against the stored prediction, plus handshake gating.
    always_comb begin
        res_entry   = entries_q[res_idx_i];
        deq_entry   = entries_q[fptr_idx];
        actual_next = res_taken_i ? res_target_i : ftq_fallthrough(res_entry.pc);
        res_ok      = res_valid_i && res_legal;
        mispredict  = res_ok && ((actual_next != res_entry.target) ||
                                 (res_taken_i && (res_cut_pos_i != res_entry.cut_pos)));
        // Only taken branches train the uBTB; not-taken mispredicts just redirect.
        upd_fire    = res_ok && res_taken_i &&
                      (!res_entry.hit || (res_target_i != res_entry.target) ||
                       (res_cut_pos_i != res_entry.cut_pos) ||
                       (res_branch_type_i != res_entry.branch_type));
        enq_ready_o = !full && !mispredict && !redirect_valid_q;
        deq_valid_o = deq_avail && !mispredict;
        enq_fire    = enq_valid_i && enq_ready_o;
        deq_fire    = deq_valid_o && deq_ready_i;
    end

    // Entry storage; stale slots are harmless since pointers bound what is visible.
    always_ff @(posedge clk) begin
        if (enq_fire) begin
            entries_q[tail_idx] <= '{pc:          enq_pc_i,
                                     target:      enq_target_i,
                                     cut_pos:     enq_cut_pos_i,
                                     hit:         enq_hit_i,
                                     branch_type: enq_branch_type_i};
        end
    end

    // Registered redirect and uBTB update, both one cycle after the resolve.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            upd_valid_q      <= 1'b0;
            upd_pc_q         <= '0;
            upd_target_q     <= '0;
            upd_cut_q        <= '0;
            upd_bt_q         <= '0;
        end else begin
            redirect_valid_q <= mispredict;
            if (mispredict) begin
                redirect_pc_q <= actual_next;
            end
            upd_valid_q <= upd_fire;
            if (upd_fire) begin
                upd_pc_q     <= res_entry.pc;
                upd_target_q <= res_target_i;
                upd_cut_q    <= res_cut_pos_i;
                upd_bt_q     <= res_branch_type_i;
            end
        end
    end

    assign deq_pc_o                  = deq_entry.pc;
    assign deq_cut_pos_o             = deq_entry.cut_pos;
    assign deq_idx_o                 = fptr_idx;
    assign redirect_valid_o          = redirect_valid_q;
    assign redirect_pc_o             = redirect_pc_q;
    assign ubtb_update_valid_o       = upd_valid_q;
    assign ubtb_update_pc_o          = upd_pc_q;
    assign ubtb_target_pc_o          = upd_target_q;
    assign ubtb_update_cut_pos_o     = upd_cut_q;
    assign ubtb_update_branch_type_o = upd_bt_q;

endmodule

// File: tb/tb_ftq_fetch_target_queue.sv
// Self-checking bench: resolve vector table plus multi-cycle sequences, with a deq scoreboard.
module tb_ftq_fetch_target_queue;
    import ftq_fetch_target_queue_pkg::*;

    localparam int unsigned DEPTH = FTQ_DEPTH;
    localparam int unsigned PTR_W = FTQ_PTR_W;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             enq_valid, enq_ready, enq_hit;
    logic [31:0]      enq_pc, enq_target;
    logic [1:0]       enq_cut_pos, enq_branch_type;
    logic             deq_valid, deq_ready;
    logic [31:0]      deq_pc;
    logic [1:0]       deq_cut_pos;
    logic [PTR_W-1:0] deq_idx;
    logic             res_valid, res_taken;
    logic [PTR_W-1:0] res_idx;
    logic [31:0]      res_target;
    logic [1:0]       res_cut_pos, res_branch_type;
    logic             commit_valid;
    logic             redirect_valid, ubtb_update_valid;
    logic [31:0]      redirect_pc, ubtb_update_pc, ubtb_target_pc;
    logic [1:0]       ubtb_update_cut_pos, ubtb_update_branch_type;
    logic [PTR_W:0]   count;

    always #5 clk = ~clk;

    ftq_fetch_target_queue #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) dut (
        .clk                       (clk),
        .rst_n                     (rst_n),
        .enq_valid_i               (enq_valid),
        .enq_ready_o               (enq_ready),
        .enq_pc_i                  (enq_pc),
        .enq_target_i              (enq_target),
        .enq_cut_pos_i             (enq_cut_pos),
        .enq_hit_i                 (enq_hit),
        .enq_branch_type_i         (enq_branch_type),
        .deq_valid_o               (deq_valid),
        .deq_ready_i               (deq_ready),
        .deq_pc_o                  (deq_pc),
        .deq_cut_pos_o             (deq_cut_pos),
        .deq_idx_o                 (deq_idx),
        .res_valid_i               (res_valid),
        .res_idx_i                 (res_idx),
        .res_taken_i               (res_taken),
        .res_target_i              (res_target),
        .res_cut_pos_i             (res_cut_pos),
        .res_branch_type_i         (res_branch_type),
        .commit_valid_i            (commit_valid),
        .redirect_valid_o          (redirect_valid),
        .redirect_pc_o             (redirect_pc),
        .ubtb_update_valid_o       (ubtb_update_valid),
        .ubtb_update_pc_o          (ubtb_update_pc),
        .ubtb_target_pc_o          (ubtb_target_pc),
        .ubtb_update_cut_pos_o     (ubtb_update_cut_pos),
        .ubtb_update_branch_type_o (ubtb_update_branch_type),
        .count_o                   (count)
    );

    typedef struct {
        logic [31:0]      pc;
        logic [1:0]       cut;
        logic [PTR_W-1:0] idx;
    } blk_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] tgt;
        logic [1:0]  cut;
        logic        hit;
        logic [1:0]  bt;
        logic        r_taken;
        logic [31:0] r_tgt;
        logic [1:0]  r_cut;
        logic [1:0]  r_bt;
        logic        e_redir;
        logic [31:0] e_rpc;
        logic        e_upd;
    } vec_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    blk_t exp_q[$];
    int   m_head = 0, m_tail = 0, m_inflight = 0;
    vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_count(input string name);
        chk(name, 32'(count), 32'(m_inflight + exp_q.size()));
    endtask

    task automatic enq(input logic [31:0] pc, input logic [31:0] tgt, input logic [1:0] cut,
                       input logic hit, input logic [1:0] bt);
        blk_t b;
        enq_valid = 1'b1; enq_pc = pc; enq_target = tgt;
        enq_cut_pos = cut; enq_hit = hit; enq_branch_type = bt;
        chk("enq_ready", 32'(enq_ready), 32'd1);
        if (enq_ready) begin
            b.pc = pc; b.cut = cut; b.idx = PTR_W'(m_tail);
            exp_q.push_back(b);
            m_tail = (m_tail + 1) % DEPTH;
        end
        step();
        enq_valid = 1'b0;
    endtask

    task automatic deq_one(input string name);
        blk_t b;
        deq_ready = 1'b1;
        if (!deq_valid) begin
            n_checks++; n_fail++;
            $display("FAIL %s_valid: got 0, expected 1", name);
        end else if (exp_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL %s_extra: got block 0x%0h, expected none", name, deq_pc);
        end else begin
            b = exp_q.pop_front();
            chk({name, "_pc"}, deq_pc, b.pc);
            chk({name, "_cut"}, 32'(deq_cut_pos), 32'(b.cut));
            chk({name, "_idx"}, 32'(deq_idx), 32'(b.idx));
            m_inflight++;
        end
        step();
        deq_ready = 1'b0;
    endtask

    task automatic commit_one();
        commit_valid = 1'b1;
        step();
        commit_valid = 1'b0;
        if (m_inflight > 0) begin
            m_inflight--;
            m_head = (m_head + 1) % DEPTH;
        end
    endtask

    task automatic resolve(input int idx, input logic taken, input logic [31:0] tgt,
                           input logic [1:0] cut, input logic [1:0] bt, input logic exp_mp);
        res_valid = 1'b1; res_idx = PTR_W'(idx); res_taken = taken;
        res_target = tgt; res_cut_pos = cut; res_branch_type = bt;
        step();
        res_valid = 1'b0;
        if (exp_mp) begin
            m_inflight = ((idx - m_head + DEPTH) % DEPTH) + 1;
            exp_q.delete();
            m_tail = (idx + 1) % DEPTH;
        end
    endtask

    task automatic chk_upd(input string name, input logic [31:0] pc, input logic [31:0] tgt,
                           input logic [1:0] cut, input logic [1:0] bt);
        chk({name, "_upd_v"}, 32'(ubtb_update_valid), 32'd1);
        chk({name, "_upd_pc"}, ubtb_update_pc, pc);
        chk({name, "_upd_tgt"}, ubtb_target_pc, tgt);
        chk({name, "_upd_cut"}, 32'(ubtb_update_cut_pos), 32'(cut));
        chk({name, "_upd_bt"}, 32'(ubtb_update_branch_type), 32'(bt));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected finish");
        $fatal(1);
    end

    initial begin
        int a;
        // pc, tgt, cut, hit, bt, taken, r_tgt, r_cut, r_bt, redirect, redirect_pc, update
        vecs[0] = '{32'h2000, 32'h2004, 2'd3, 1'b0, 2'd0, 1'b0, 32'h0, 2'd0, 2'd0,
                    1'b0, 32'h0, 1'b0};
        vecs[1] = '{32'h3000, 32'h3004, 2'd3, 1'b0, 2'd0, 1'b1, 32'h4000, 2'd2, 2'd1,
                    1'b1, 32'h4000, 1'b1};
        vecs[2] = '{32'h5000, 32'h5100, 2'd1, 1'b1, 2'd1, 1'b0, 32'h0, 2'd0, 2'd1,
                    1'b1, 32'h5004, 1'b0};
        vecs[3] = '{32'h6000, 32'h6100, 2'd2, 1'b1, 2'd2, 1'b1, 32'h6100, 2'd2, 2'd2,
                    1'b0, 32'h0, 1'b0};
        vecs[4] = '{32'h7000, 32'h7200, 2'd1, 1'b1, 2'd1, 1'b1, 32'h7200, 2'd3, 2'd1,
                    1'b1, 32'h7200, 1'b1};
        vecs[5] = '{32'h8000, 32'h8040, 2'd0, 1'b0, 2'd2, 1'b1, 32'h8040, 2'd0, 2'd2,
                    1'b0, 32'h0, 1'b1};
        vecs[6] = '{32'h9000, 32'h9010, 2'd1, 1'b1, 2'd1, 1'b1, 32'h9010, 2'd1, 2'd3,
                    1'b0, 32'h0, 1'b1};

        rst_n = 1'b0;
        enq_valid = 1'b0; enq_pc = '0; enq_target = '0; enq_cut_pos = '0;
        enq_hit = 1'b0; enq_branch_type = '0; deq_ready = 1'b0;
        res_valid = 1'b0; res_idx = '0; res_taken = 1'b0; res_target = '0;
        res_cut_pos = '0; res_branch_type = '0; commit_valid = 1'b0;
        step(); step();
        rst_n = 1'b1;
        step();

        // Reset state.
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_deq_valid", 32'(deq_valid), 32'd0);
        chk("rst_redirect_v", 32'(redirect_valid), 32'd0);
        chk("rst_redirect_pc", redirect_pc, 32'd0);
        chk("rst_upd_v", 32'(ubtb_update_valid), 32'd0);
        chk("rst_enq_ready", 32'(enq_ready), 32'd1);

        // Fill to full, try one more, then drain in order.
        for (int i = 0; i < 8; i++) enq(32'h1000 + 32'(4 * i), 32'h1004 + 32'(4 * i),
                                        2'(i), 1'b1, BRANCH_TYPE_NONE);
        chk("full_enq_ready", 32'(enq_ready), 32'd0);
        chk_count("full_count");
        enq_valid = 1'b1; enq_pc = 32'hDEAD;
        step();
        enq_valid = 1'b0;
        chk_count("full_blocked_count");
        for (int i = 0; i < 8; i++) deq_one($sformatf("drain%0d", i));
        for (int i = 0; i < 8; i++) commit_one();
        chk_count("drain_count");

        // Single-entry resolve vectors.
        for (int i = 0; i < 7; i++) begin
            a = m_tail;
            enq(vecs[i].pc, vecs[i].tgt, vecs[i].cut, vecs[i].hit, vecs[i].bt);
            deq_one($sformatf("v%0d_deq", i));
            resolve(a, vecs[i].r_taken, vecs[i].r_tgt, vecs[i].r_cut, vecs[i].r_bt,
                    vecs[i].e_redir);
            chk($sformatf("v%0d_redir_v", i), 32'(redirect_valid), 32'(vecs[i].e_redir));
            if (vecs[i].e_redir) chk($sformatf("v%0d_redir_pc", i), redirect_pc, vecs[i].e_rpc);
            if (vecs[i].e_upd) begin
                chk_upd($sformatf("v%0d", i), vecs[i].pc, vecs[i].r_tgt, vecs[i].r_cut,
                        vecs[i].r_bt);
            end else begin
                chk($sformatf("v%0d_upd_v", i), 32'(ubtb_update_valid), 32'd0);
            end
            step();
            chk($sformatf("v%0d_redir_clear", i), 32'(redirect_valid), 32'd0);
            commit_one();
            chk_count($sformatf("v%0d_count", i));
        end

        // Taken miss with four younger entries (two issued, three pending... total five).
        a = m_tail;
        enq(32'h3000, 32'h3004, 2'd3, 1'b0, BRANCH_TYPE_NONE);
        for (int i = 1; i < 5; i++) enq(32'h3000 + 32'(16 * i), 32'h3004 + 32'(16 * i),
                                        2'd3, 1'b1, BRANCH_TYPE_NONE);
        deq_one("miss_deq0");
        deq_one("miss_deq1");
        chk_count("miss_count_before");
        resolve(a, 1'b1, 32'h4000, 2'd2, BRANCH_TYPE_COND, 1'b1);
        chk_count("miss_count_after");
        chk("miss_count_one", 32'(count), 32'd1);
        chk("miss_deq_valid", 32'(deq_valid), 32'd0);
        chk("miss_redir_v", 32'(redirect_valid), 32'd1);
        chk("miss_redir_pc", redirect_pc, 32'h4000);
        chk("miss_enq_blocked", 32'(enq_ready), 32'd0);
        chk_upd("miss", 32'h3000, 32'h4000, 2'd2, BRANCH_TYPE_COND);
        step();
        commit_one();
        chk_count("miss_count_final");

        // Illegal resolves and commit with nothing issued.
        a = m_tail;
        enq(32'hA000, 32'hA004, 2'd0, 1'b1, BRANCH_TYPE_NONE);
        enq(32'hA010, 32'hA014, 2'd0, 1'b1, BRANCH_TYPE_NONE);
        deq_one("ill_deq0");
        resolve((a + 1) % DEPTH, 1'b1, 32'hB000, 2'd1, BRANCH_TYPE_JUMP, 1'b0);
        chk("ill_fptr_redir", 32'(redirect_valid), 32'd0);
        chk("ill_fptr_upd", 32'(ubtb_update_valid), 32'd0);
        chk_count("ill_fptr_count");
        resolve((a + DEPTH - 1) % DEPTH, 1'b1, 32'hB000, 2'd1, BRANCH_TYPE_JUMP, 1'b0);
        chk("ill_old_redir", 32'(redirect_valid), 32'd0);
        chk_count("ill_old_count");
        commit_one();
        chk_count("ill_commit1");
        commit_one();
        chk_count("ill_commit_empty");
        deq_one("ill_deq1");
        commit_one();
        chk_count("ill_final");

        // Wrap-around traffic, then flush at idx 1 after wrapping.
        for (int i = 0; i < 20; i++) begin
            enq(32'hC000 + 32'(4 * i), 32'hC004 + 32'(4 * i), 2'd0, 1'b1, BRANCH_TYPE_NONE);
            deq_one($sformatf("wrap%0d", i));
            commit_one();
        end
        chk_count("wrap_count");
        for (int i = 0; i < 8 && m_tail != 0; i++) begin
            enq(32'hC800, 32'hC804, 2'd0, 1'b1, BRANCH_TYPE_NONE);
            deq_one("align");
            commit_one();
        end
        for (int i = 0; i < 4; i++) enq(32'hD000 + 32'(16 * i), 32'hD004 + 32'(16 * i),
                                        2'd0, 1'b0, BRANCH_TYPE_NONE);
        for (int i = 0; i < 3; i++) deq_one($sformatf("wflush_deq%0d", i));
        resolve(1, 1'b1, 32'hC000_0000, 2'd1, BRANCH_TYPE_JUMP, 1'b1);
        chk_count("wflush_count");
        chk("wflush_count_two", 32'(count), 32'd2);
        chk("wflush_redir_pc", redirect_pc, 32'hC000_0000);
        step();
        enq(32'hE000, 32'hE004, 2'd1, 1'b1, BRANCH_TYPE_NONE);
        deq_one("wflush_new");
        for (int i = 0; i < 3; i++) commit_one();
        chk_count("wflush_final");

        // Back-to-back redirects: younger first, then older in the redirect cycle.
        a = m_tail;
        enq(32'hF000, 32'hF004, 2'd0, 1'b1, BRANCH_TYPE_COND);
        enq(32'hF100, 32'hF104, 2'd0, 1'b1, BRANCH_TYPE_COND);
        deq_one("b2b_deq0");
        deq_one("b2b_deq1");
        resolve((a + 1) % DEPTH, 1'b1, 32'h1234_0000, 2'd0, BRANCH_TYPE_COND, 1'b1);
        chk("b2b_redir1_pc", redirect_pc, 32'h1234_0000);
        chk("b2b_redir_enq_blk", 32'(enq_ready), 32'd0);
        resolve(a, 1'b1, 32'h5678_0000, 2'd0, BRANCH_TYPE_COND, 1'b1);
        chk("b2b_redir2_v", 32'(redirect_valid), 32'd1);
        chk("b2b_redir2_pc", redirect_pc, 32'h5678_0000);
        chk_count("b2b_count");
        step();
        chk("b2b_redir_clear", 32'(redirect_valid), 32'd0);
        commit_one();
        chk_count("b2b_final");

        // Reset mid-stream with a redirect pending.
        a = m_tail;
        for (int i = 0; i < 5; i++) enq(32'h9100 + 32'(16 * i), 32'h9104 + 32'(16 * i),
                                        2'd0, 1'b0, BRANCH_TYPE_NONE);
        deq_one("rst_deq0");
        deq_one("rst_deq1");
        resolve((a + 1) % DEPTH, 1'b1, 32'hAAAA_0000, 2'd0, BRANCH_TYPE_NONE, 1'b1);
        chk("mid_redir_pending", 32'(redirect_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        m_head = 0; m_tail = 0; m_inflight = 0;
        exp_q.delete();
        chk("mid_rst_count", 32'(count), 32'd0);
        chk("mid_rst_deq_valid", 32'(deq_valid), 32'd0);
        chk("mid_rst_redir", 32'(redirect_valid), 32'd0);
        chk("mid_rst_upd", 32'(ubtb_update_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        enq(32'h7700, 32'h7704, 2'd2, 1'b1, BRANCH_TYPE_NONE);
        deq_one("post_rst");
        commit_one();
        chk_count("post_rst_count");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ftq_fetch_target_queue.md
Name: ftq_fetch_target_queue

Overview:
- Fetch target queue between the uBTB prediction stage and the instruction fetch unit (IFU).
- Buffers one uBTB prediction per fetch block: pc, predicted next_fetch_pc, cut_pos, hit, branch_type.
- Issues fetch blocks to the IFU in order, accepts branch resolution from the backend, detects mispredicts and flushes younger entries.
- Generates the redirect to PC-gen and the uBTB update write. Entries retire on in-order commit.

Parameters:
- DEPTH, 8, number of entries; power of two, at least 2.
- PTR_W, 3, log2(DEPTH); queue pointers are PTR_W+1 bits wide (includes a wrap bit).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- enq_valid  in  1  uBTB prediction present
- enq_ready  out  1  queue accepts enqueue this cycle
- enq_pc  in  32  fetch block PC
- enq_target  in  32  predicted next_fetch_pc from uBTB
- enq_cut_pos  in  2  predicted cut position
- enq_hit  in  1  uBTB hit
- enq_branch_type  in  2  predicted branch type
- deq_valid  out  1  fetch block available to IFU
- deq_ready  in  1  IFU takes block
- deq_pc  out  32  block PC
- deq_cut_pos  out  2  block cut position
- deq_idx  out  PTR_W  FTQ index tag carried with the block
- res_valid  in  1  branch resolved
- res_idx  in  PTR_W  FTQ index being resolved
- res_taken  in  1  actual taken
- res_target  in  32  actual taken target
- res_cut_pos  in  2  actual cut position
- res_branch_type  in  2  actual branch type
- commit_valid  in  1  retire oldest entry
- redirect_valid  out  1  one-cycle redirect pulse to PC-gen
- redirect_pc  out  32  correct fetch PC
- ubtb_update_valid  out  1  uBTB write strobe
- ubtb_update_pc, ubtb_target_pc  out  32 each  uBTB update PC and target
- ubtb_update_cut_pos, ubtb_update_branch_type  out  2 each  uBTB update fields
- count  out  PTR_W+1  occupied entries

Behaviour:

Pointers and storage:
- Pointers are head (commit), fptr (next to send to IFU) and tail (next free slot).
- Invariant: head <= fptr <= tail in wrap order.
- empty = (head == tail).
- full = (low bits equal and wrap bits differ).
- count = tail - head, computed modulo 2^(PTR_W+1).

Enqueue:
- enq_ready = !full && !mispredict && !redirect_valid.
- On enq_valid && enq_ready, write the entry at tail and advance tail.

Dequeue:
- deq_valid = (fptr != tail) && !mispredict.
- On deq_valid && deq_ready, advance fptr.
- Output fields are driven combinationally from entry[fptr].

Resolve:
- A resolve is legal only if res_idx lies in [head, fptr). Otherwise it is ignored.
- actual_next = res_taken ? res_target : pc+4, where pc is the entry's stored PC.
- mispredict = legal && (actual_next != entry.target || (res_taken && res_cut_pos != entry.cut_pos)).
- On mispredict:
  - tail <= res_idx+1 and fptr <= res_idx+1; wrap bits are taken from the fptr/head relation.
  - All younger entries are squashed.

Redirect (registered, 1-cycle latency):
- Next cycle: redirect_valid = 1, redirect_pc = actual_next.
- Otherwise redirect_valid = 0.

uBTB update (registered, same cycle as redirect):
- Condition: legal resolve with res_taken && (!entry.hit || target mismatch || cut_pos mismatch || branch_type mismatch).
- ubtb_update_valid = 1 with update_pc = entry pc, target = res_target, cut_pos = res_cut_pos, branch_type = res_branch_type.
- A not-taken mispredict causes a redirect but no uBTB update.

Commit:
- commit_valid pops head when head != fptr.
- commit_valid when head == fptr is ignored.

Simultaneous events:
- enq and deq in the same cycle are both allowed.
- Commit in the same cycle as a mispredict is applied, and the head update is independent of the tail/fptr rewrite.
- Enqueue in the mispredict cycle or the redirect cycle is blocked by enq_ready.
- A second res_valid in the redirect cycle is processed normally (back-to-back redirects are allowed).

Full and wrap:
- full blocks enqueue only.
- Indices wrap modulo DEPTH.

Reset:
- head, fptr, tail = 0; count = 0.
- redirect_valid and ubtb_update_valid = 0; all registered output data = 0.
- Reset asserted mid-operation discards all entries immediately.

Decomposition:
- Shared package (defs.sv) holds: ftq_entry_t (pc, target, cut_pos, hit, branch_type), FTQ_DEPTH, FTQ_PTR_W, and the existing BRANCH_TYPE_* constants.
- One natural sub-module: ftq_ptr_ctrl, which holds pointer arithmetic, full/empty/count and the flush rewind.
- Storage and resolve compare stay in the top-level module.

Test Plan:
- Fill/drain: enqueue 8 blocks pc=0x1000..0x101C with deq_ready=0 -> enq_ready=0 and count=8. Set deq_ready=1 -> deq_pc sequence 0x1000..0x101C with deq_idx 0..7.
- Correct prediction: entry pc=0x2000, target=0x2004, hit=0; resolve res_taken=0 -> no redirect and no ubtb_update_valid.
- Taken miss: entry pc=0x3000, hit=0, target=0x3004, four younger entries present; resolve res_taken=1, res_target=0x4000, res_cut_pos=2 -> next cycle redirect_pc=0x4000 and ubtb_update_valid with pc 0x3000 / target 0x4000 / cut 2. tail = res_idx+1 and count drops by 4.
- Wrap-around: cycle 20 blocks through with commits -> indices wrap 7->0, a flush at idx 1 after the wrap rewinds tail correctly, count stays consistent.
- Illegal inputs: res_idx outside [head, fptr) and commit_valid with head==fptr -> no state change.
- Reset mid-stream with 5 entries queued and a redirect pending -> count=0, deq_valid=0, redirect_valid=0 on the next edge.
